// File: rtl/staged_magnitude_comparator.sv
// Multi-cycle magnitude comparator: one DIGIT-bit slice per clock, MSB slice first.
// Build option: define STAGED_COMPARE_EARLY_EXIT_EN to stop on the first unequal slice.
`timescale 1ns/1ps

module staged_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               signed_q, signed_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               decided_q, decided_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   slice_a;
    logic [DIGIT-1:0]   slice_b;
    logic               sign_split;
    logic               slice_gt;
    logic               slice_lt;
    logic               slice_differs;
    logic               exit_now;

    always_comb begin
        slice_a = a_q[int'(index_q)*DIGIT +: DIGIT];
        slice_b = b_q[int'(index_q)*DIGIT +: DIGIT];

        // Differing sign bits on the MSB slice settle a signed compare outright.
        sign_split = signed_q && (index_q == TOP_IDX) && (a_q[WIDTH-1] != b_q[WIDTH-1]);
        if (sign_split) begin
            slice_gt = ~a_q[WIDTH-1];
            slice_lt = a_q[WIDTH-1];
        end else begin
            slice_gt = slice_a > slice_b;
            slice_lt = slice_a < slice_b;
        end
        slice_differs = slice_gt | slice_lt;

`ifdef STAGED_COMPARE_EARLY_EXIT_EN
        exit_now = (index_q == '0) || slice_differs;
`else
        exit_now = (index_q == '0);
`endif
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        index_d   = index_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    signed_d  = signed_mode;
                    index_d   = TOP_IDX;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    eq_d      = 1'b0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                // Only the first unequal slice may set the verdict.
                if (!decided_q && slice_differs) begin
                    gt_d      = slice_gt;
                    lt_d      = slice_lt;
                    decided_d = 1'b1;
                end
                if (exit_now) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!decided_q && !slice_differs) begin
                        eq_d = 1'b1;
                    end
                end else begin
                    index_d = index_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            index_q   <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            index_q   <= index_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
            done_q    <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == COMPARE);
    assign done  = done_q;
    assign gt    = gt_q;
    assign lt    = lt_q;
    assign eq    = eq_q;

endmodule

// File: doc/staged_magnitude_comparator.md
Name: staged_magnitude_comparator

Overview:
- Multi-cycle, parametrised successor to the combinational greater-than comparators.
- Compares two WIDTH-bit operands one DIGIT-bit slice per clock, starting at the MSB slice and moving down.
- Supports unsigned and two's-complement signed compare.
- Reports exactly one of gt, lt or eq through a start/done handshake.
- Used where wide compares must not form a long combinational chain, for example sorters and threshold checkers in later chapters.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of DIGIT and at least 2.
- DIGIT, 2, bits compared per cycle. Must be at least 1. NUM_DIGITS = WIDTH/DIGIT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare; accepted only when ready=1.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  block is idle and can accept start.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse: result valid.
- gt  output  1  A > B.
- lt  output  1  A < B.
- eq  output  1  A == B.

Interface (already decided):
- One clock, clk.
- Reset is synchronous and active-high, named reset.

Behaviour:
- Reset: FSM goes to IDLE; ready=1, busy=0, done=0, gt=lt=eq=0; operand registers and slice index cleared.
- Reset has priority over everything else, including mid-compare. It aborts the compare with no done pulse.
- FSM states: IDLE, COMPARE.
- IDLE:
  - ready=1, busy=0.
  - If start=1: latch a, b and signed_mode; set index = NUM_DIGITS-1; clear decided flag; go to COMPARE.
  - On that same edge clear gt/lt/eq.
- COMPARE:
  - ready=0, busy=1.
  - Each cycle, compare slice a[index*DIGIT +: DIGIT] against the matching slice of b, unsigned.
  - MSB slice in signed mode: if the operand sign bits differ, the operand with sign 0 is greater and the rest of the slice is ignored. If the sign bits are equal, compare the slice unsigned.
  - First unequal slice: set gt or lt accordingly and set decided.
  - At index 0, if no slice differed, set eq=1.
- Leaving COMPARE:
  - Registers done=1 for exactly one cycle and returns the FSM to IDLE on the same edge.
  - The exit condition depends on the build; see Optional Feature.
- Latency:
  - Let k = number of slices examined.
  - Start is accepted on edge E0; done is high in the cycle following edge Ek.
  - eq always needs k = NUM_DIGITS.
- gt/lt/eq:
  - Registered, mutually exclusive, exactly one set at done.
  - Held stable after done until the next accepted start, which clears them.
- start while busy=1 is ignored; latched operands are unaffected.
- start in the same cycle as done: FSM is already IDLE, so start is accepted. Back-to-back compares are allowed with no gap cycle.
- Changing a, b or signed_mode after acceptance has no effect on the current compare.
- index decrements by 1 per COMPARE cycle and never wraps. A compare terminates at index 0 at the latest.

Optional Feature:
- Macro: STAGED_COMPARE_EARLY_EXIT_EN.
- Defined (early exit):
  - COMPARE exits on the first unequal slice, or at index 0.
  - Latency = 1 + number of leading equal slices.
- Undefined (constant time):
  - COMPARE always runs all NUM_DIGITS slices.
  - The first decision is sticky; later slices cannot change gt/lt.
  - Latency is always NUM_DIGITS, independent of the data.
- Final gt/lt/eq values are identical in both builds.

Test Plan (WIDTH=16, DIGIT=2):
- a=0x8000, b=0x7FFF, signed_mode=0 -> gt=1, lt=0, eq=0. Done 1 cycle after accept with EARLY_EXIT_EN, 8 cycles without.
- a=b=0x1234 -> eq=1, gt=lt=0, done 8 cycles after accept in both builds. Results hold after done until the next start.
- a=0x8000, b=0x0001 -> signed_mode=1 gives lt=1; signed_mode=0 gives gt=1. With early exit, latency is 1 in both cases.
- a=0x0003, b=0x0002, signed_mode=0 -> gt=1 at 8 cycles, since the difference is in the LSB slice. A second start with a=0x0000, b=0xFFFF issued 3 cycles into the compare is ignored; the result is still gt.
- Start a=0x0001, b=0x0002, then assert reset for 1 cycle at cycle 3 -> no done pulse. Next cycle: ready=1, busy=0, gt=lt=eq=0. A new start then completes normally with lt=1.
- Assert start in the done cycle with a=0xFFFF, b=0x0000, signed_mode=1 -> accepted with no idle gap; next result is lt=1.
